// File: rtl/anton_neopixel_multi_stream.sv
// Multi-channel NeoPixel frame streamer: fetches one pixel word per channel
// and serialises all channels in lockstep, followed by a sync-low gap.
module anton_neopixel_multi_stream #(
  parameter int CHANNELS    = 4,
  parameter int PIXEL_MAX   = 255,
  parameter int RESET_DELAY = 400,
  localparam int AW = $clog2(PIXEL_MAX + 1)
) (
  input  logic                  clk6_4mhz,
  input  logic                  resetN,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  loop,
  input  logic                  mode32,
  input  logic [AW-1:0]         pixelCount,
  output logic                  pixReq,
  output logic [AW-1:0]         pixAddr,
  input  logic                  pixAck,
  input  logic [CHANNELS*32-1:0] pixData,
  output logic [CHANNELS-1:0]   neoData,
  output logic                  busy,
  output logic                  frameDone,
  output logic                  underrun,
  input  logic                  clearUnderrun
);

  localparam int SW = (RESET_DELAY > 1) ? $clog2(RESET_DELAY) : 1;

  typedef enum logic [1:0] {IDLE, FETCH, STREAM, SYNC} state_t;

  state_t        state;
  logic [AW-1:0] last;
  logic [AW-1:0] pix;
  logic          m32;
  logic          stop_pend;
  logic          nxt_valid;
  logic [2:0]    phase;
  logic [4:0]    bitn;
  logic [SW-1:0] sync_cnt;
  logic [31:0]   shift [CHANNELS];
  logic [31:0]   nxt   [CHANNELS];

  logic bit_last;
  logic pix_first;
  logic pix_end;
  logic sync_end;
  logic ack;

  // Pixels are kept MSB-aligned so bit 31 is always the bit on the wire.
  function automatic logic [31:0] align(input logic [31:0] d, input logic m);
    return m ? d : {d[23:0], 8'h00};
  endfunction

  assign bit_last  = bitn == (m32 ? 5'd31 : 5'd23);
  assign pix_first = (state == STREAM) && (phase == 3'd0) && (bitn == 5'd0);
  assign pix_end   = (state == STREAM) && (phase == 3'd7) && bit_last;
  assign sync_end  = (state == SYNC) && (sync_cnt == SW'(RESET_DELAY - 1));
  assign ack       = pixReq && pixAck;
  assign busy      = state != IDLE;
  assign frameDone = sync_end;

  always_comb begin
    neoData = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      neoData[c] = (state == STREAM) &&
                   (phase < (shift[c][31] ? 3'd5 : 3'd2));
    end
  end

  always_ff @(posedge clk6_4mhz or negedge resetN) begin
    if (!resetN) begin
      state     <= IDLE;
      pixReq    <= 1'b0;
      pixAddr   <= '0;
      last      <= '0;
      pix       <= '0;
      m32       <= 1'b0;
      stop_pend <= 1'b0;
      nxt_valid <= 1'b0;
      underrun  <= 1'b0;
      phase     <= '0;
      bitn      <= '0;
      sync_cnt  <= '0;
      for (int c = 0; c < CHANNELS; c++) begin
        shift[c] <= '0;
        nxt[c]   <= '0;
      end
    end else begin
      if (ack) pixReq <= 1'b0;
      if (stop && state != IDLE) stop_pend <= 1'b1;
      if (clearUnderrun) underrun <= 1'b0;

      unique case (state)
        IDLE: begin
          if (start) begin
            state     <= FETCH;
            pixReq    <= 1'b1;
            pixAddr   <= '0;
            m32       <= mode32;
            last      <= pixelCount;
            stop_pend <= 1'b0;
            nxt_valid <= 1'b0;
          end
        end
        FETCH: begin
          if (ack) begin
            state <= STREAM;
            phase <= '0;
            bitn  <= '0;
            pix   <= '0;
            for (int c = 0; c < CHANNELS; c++)
              shift[c] <= align(pixData[32*c +: 32], m32);
          end
        end
        STREAM: begin
          if (ack) begin
            nxt_valid <= 1'b1;
            for (int c = 0; c < CHANNELS; c++)
              nxt[c] <= align(pixData[32*c +: 32], m32);
          end
          if (pix_first && pix != last) begin
            pixReq  <= 1'b1;
            pixAddr <= pix + AW'(1);
          end
          if (pix_end) begin
            phase <= '0;
            bitn  <= '0;
            if (pix == last) begin
              state    <= SYNC;
              sync_cnt <= '0;
            end else if (nxt_valid) begin
              nxt_valid <= 1'b0;
              pix       <= pix + AW'(1);
              for (int c = 0; c < CHANNELS; c++)
                shift[c] <= nxt[c];
            end else begin
              underrun <= 1'b1;
              state    <= SYNC;
              sync_cnt <= '0;
            end
          end else begin
            phase <= phase + 3'd1;
            if (phase == 3'd7) begin
              bitn <= bitn + 5'd1;
              for (int c = 0; c < CHANNELS; c++)
                shift[c] <= {shift[c][30:0], 1'b0};
            end
          end
        end
        SYNC: begin
          sync_cnt <= sync_cnt + SW'(1);
          if (sync_end) begin
            stop_pend <= 1'b0;
            nxt_valid <= 1'b0;
            if (loop && !(stop_pend || stop)) begin
              state   <= FETCH;
              pixReq  <= 1'b1;
              pixAddr <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_anton_neopixel_multi_stream.sv
// Randomised bench for anton_neopixel_multi_stream: a pixel memory responder
// plus a waveform model derived from pixel bits, timing and frame rules.
module tb_anton_neopixel_multi_stream;

  localparam int RD = 400;

  logic        clk = 1'b0;
  logic        resetN;
  logic        start;
  logic        stop;
  logic        loop;
  logic        mode32;
  logic [7:0]  pixelCount;
  logic        pixReq;
  logic [7:0]  pixAddr;
  logic        pixAck;
  logic [63:0] pixData;
  logic [1:0]  neoData;
  logic        busy;
  logic        frameDone;
  logic        underrun;
  logic        clearUnderrun;

  anton_neopixel_multi_stream #(
    .CHANNELS(2), .PIXEL_MAX(255), .RESET_DELAY(RD)
  ) dut (
    .clk6_4mhz(clk), .resetN(resetN), .start(start), .stop(stop),
    .loop(loop), .mode32(mode32), .pixelCount(pixelCount),
    .pixReq(pixReq), .pixAddr(pixAddr), .pixAck(pixAck),
    .pixData(pixData), .neoData(neoData), .busy(busy),
    .frameDone(frameDone), .underrun(underrun),
    .clearUnderrun(clearUnderrun)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [63:0] mem [256];
  int          lat [256];
  int          acks [$];
  int          wait_cnt = 0;
  int          hs_err = 0;
  int          ack_addr = 0;
  bit          ack_now = 0;
  bit          prev_ack = 0;

  // One cycle: sample at negedge, then act as the pixel memory.
  task automatic step();
    @(negedge clk);
    if (prev_ack && pixReq === 1'b1) hs_err++;
    ack_now = 0;
    pixAck  = 1'b0;
    pixData = {$urandom, $urandom};
    if (pixReq === 1'b1) begin
      wait_cnt++;
      if (wait_cnt > lat[pixAddr]) begin
        pixAck   = 1'b1;
        pixData  = mem[pixAddr];
        ack_now  = 1;
        ack_addr = int'(pixAddr);
        acks.push_back(int'(pixAddr));
        wait_cnt = 0;
      end
    end else begin
      wait_cnt = 0;
    end
    prev_ack = ack_now;
  endtask

  task automatic fill(input int cnt, input int maxlat);
    for (int i = 0; i <= cnt; i++) begin
      mem[i] = {$urandom, $urandom};
      lat[i] = $urandom_range(maxlat, 0);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) step();
    vectors++;
    if (pixReq !== 1'b0 || pixAddr !== 8'd0) begin
      miscompares++;
      $display("FAIL reset_req: req=%b addr=%0d want 0/0", pixReq, pixAddr);
    end
    vectors++;
    if (busy !== 1'b0 || frameDone !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy: busy=%b fd=%b want 0/0", busy, frameDone);
    end
    vectors++;
    if (neoData !== 2'b00 || underrun !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_out: neo=%b und=%b want 00/0", neoData, underrun);
    end
    resetN = 1'b1;
    repeat (2) step();
    vectors++;
    if (pixReq !== 1'b0 || busy !== 1'b0 || neoData !== 2'b00) begin
      miscompares++;
      $display("FAIL post_reset_idle: req=%b busy=%b neo=%b want 0/0/00",
               pixReq, busy, neoData);
    end
  endtask

  // One frame, no looping; hold>0 withholds the ack of pixel 'hold'.
  task automatic test_frame(input string name, input bit m, input int cnt,
                            input int hold);
    int nb, p, s, nstr, j, t, bad, pre_bad, nack, pix, r, b, ph;
    bit got, eund, seq_ok, efd, ebusy, eu;
    logic [1:0] eneo;
    logic [4:0] obs_v, exp_v;
    logic [31:0] d;
    nb = m ? 32 : 24;
    p = 8 * nb;
    nstr = (hold > 0) ? hold : cnt + 1;
    eund = hold > 0;
    if (hold > 0) lat[hold] = 300;
    s = nstr * p;
    obs_v = '0;
    exp_v = '0;
    acks.delete();
    hs_err = 0;
    mode32 = m;
    pixelCount = 8'(cnt);
    loop = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (pixReq !== 1'b1 || pixAddr !== 8'd0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL %s start_req: req=%b addr=%0d busy=%b want 1/0/1",
               name, pixReq, pixAddr, busy);
    end
    pre_bad = 0;
    got = ack_now && ack_addr == 0;
    t = 0;
    while (!got && t < 100) begin
      step();
      t++;
      if (neoData !== 2'b00 || busy !== 1'b1) pre_bad++;
      got = ack_now && ack_addr == 0;
    end
    vectors++;
    if (!got || pre_bad != 0) begin
      miscompares++;
      $display("FAIL %s fetch: got_ack=%0d bad_cycles=%0d want 1/0",
               name, got, pre_bad);
      return;
    end
    bad = -1;
    for (j = 0; j <= s + RD; j++) begin
      step();
      eneo = 2'b00;
      if (j < s) begin
        pix = j / p;
        r = j % p;
        b = r / 8;
        ph = r % 8;
        for (int c = 0; c < 2; c++) begin
          d = mem[pix][32*c +: 32];
          eneo[c] = ph < (d[nb-1-b] ? 5 : 2);
        end
      end
      efd = j == s + RD - 1;
      ebusy = j < s + RD;
      eu = eund && j >= s;
      if (bad < 0 &&
          (neoData !== eneo || frameDone !== efd ||
           busy !== ebusy || underrun !== eu)) begin
        bad = j;
        obs_v = {neoData, frameDone, busy, underrun};
        exp_v = {eneo, efd, ebusy, eu};
      end
    end
    vectors++;
    if (bad >= 0) begin
      miscompares++;
      $display("FAIL %s wave at cycle %0d: {neo,fd,busy,und}=%b want %b",
               name, bad, obs_v, exp_v);
    end
    vectors++;
    if (hs_err != 0) begin
      miscompares++;
      $display("FAIL %s handshake: req high after ack %0d times want 0",
               name, hs_err);
    end
    nack = eund ? hold + 1 : cnt + 1;
    seq_ok = acks.size() == nack;
    for (int i = 0; i < acks.size(); i++)
      if (acks[i] != i) seq_ok = 0;
    vectors++;
    if (!seq_ok) begin
      miscompares++;
      $display("FAIL %s addr_seq: %0d acks seen want %0d in order 0..%0d",
               name, acks.size(), nack, nack - 1);
    end
    if (eund) begin
      clearUnderrun = 1'b1;
      step();
      clearUnderrun = 1'b0;
      vectors++;
      if (underrun !== 1'b0) begin
        miscompares++;
        $display("FAIL %s clear_underrun: und=%b want 0", name, underrun);
      end
    end
  endtask

  task automatic test_directed();
    fill(1, 0);
    mem[0][31:0] = {8'($urandom), 24'h800001};
    test_frame("d24", 1'b0, 1, 0);
  endtask

  task automatic test_mode32();
    fill(2, 10);
    mem[0][31:0] = 32'hFF000000;
    test_frame("m32", 1'b1, 2, 0);
  endtask

  task automatic test_random();
    int cnt;
    repeat (4) begin
      cnt = $urandom_range(3, 0);
      fill(cnt, 15);
      test_frame("rnd", 1'($urandom_range(1, 0)), cnt, 0);
    end
  endtask

  task automatic test_underrun();
    fill(2, 5);
    test_frame("und1", 1'b0, 2, 1);
    fill(3, 5);
    test_frame("und2", 1'b0, 3, 2);
  endtask

  task automatic test_loop();
    int nb, ones, h, fd, fd_cyc, hi, t;
    bit m, prev_fd, stopped, seq_ok;
    logic [31:0] d;
    m = 1'($urandom_range(1, 0));
    nb = m ? 32 : 24;
    fill(0, 5);
    d = mem[0][31:0];
    ones = m ? $countones(d) : $countones(d[23:0]);
    h = 5 * ones + 2 * (nb - ones);
    acks.delete();
    hs_err = 0;
    loop = 1'b1;
    pixelCount = 8'd0;
    mode32 = m;
    step();
    stop = 1'b1;
    step();
    stop = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    fd = 0;
    fd_cyc = 0;
    hi = 0;
    prev_fd = 0;
    stopped = 0;
    for (t = 0; t < 20000; t++) begin
      step();
      if (frameDone === 1'b1) fd_cyc++;
      if (frameDone === 1'b1 && !prev_fd) fd++;
      prev_fd = frameDone === 1'b1;
      if (neoData[0] === 1'b1) hi++;
      if (busy !== 1'b1) break;
      start = (t % 97) == 50;
      if (fd == 2 && !stopped && neoData[0] === 1'b1) begin
        stop = 1'b1;
        stopped = 1;
      end else begin
        stop = 1'b0;
      end
    end
    start = 1'b0;
    stop = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL loop_timeout: busy=%b after %0d cycles want 0", busy, t);
    end
    vectors++;
    if (fd != 3 || fd_cyc != 3) begin
      miscompares++;
      $display("FAIL loop_frames: pulses=%0d high_cycles=%0d want 3/3",
               fd, fd_cyc);
    end
    vectors++;
    if (hi != 3 * h) begin
      miscompares++;
      $display("FAIL loop_high_time: ch0 high %0d cycles want %0d", hi, 3 * h);
    end
    seq_ok = acks.size() == 3;
    foreach (acks[i]) if (acks[i] != 0) seq_ok = 0;
    vectors++;
    if (!seq_ok || hs_err != 0) begin
      miscompares++;
      $display("FAIL loop_fetch: acks=%0d hs_err=%0d want 3/0",
               acks.size(), hs_err);
    end
    loop = 1'b0;
    repeat (5) step();
    vectors++;
    if (busy !== 1'b0 || pixReq !== 1'b0) begin
      miscompares++;
      $display("FAIL loop_idle: busy=%b req=%b want 0/0", busy, pixReq);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    fill(3, 0);
    mode32 = 1'b0;
    pixelCount = 8'd3;
    loop = 1'b0;
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    found = 0;
    for (int t = 0; t < 100 && !found; t++) begin
      step();
      if (pixReq === 1'b1 && neoData !== 2'b00 && busy === 1'b1) found = 1;
    end
    vectors++;
    if (!found) begin
      miscompares++;
      $display("FAIL rst_mid_setup: streaming with req never seen want seen");
    end
    resetN = 1'b0;
    pixAck = 1'b0;
    #1;
    vectors++;
    if (neoData !== 2'b00 || pixReq !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_async: neo=%b req=%b want 00/0", neoData, pixReq);
    end
    vectors++;
    if (busy !== 1'b0 || pixAddr !== 8'd0) begin
      miscompares++;
      $display("FAIL rst_async_state: busy=%b addr=%0d want 0/0",
               busy, pixAddr);
    end
    step();
    step();
    resetN = 1'b1;
    step();
    step();
    vectors++;
    if (pixReq !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_after: req=%b busy=%b want 0/0", pixReq, busy);
    end
    lat[0] = 50;
    start = 1'b1;
    step();
    start = 1'b0;
    vectors++;
    if (pixReq !== 1'b1 || pixAddr !== 8'd0) begin
      miscompares++;
      $display("FAIL rst_restart: req=%b addr=%0d want 1/0", pixReq, pixAddr);
    end
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    step();
  endtask

  initial begin
    resetN = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    loop = 1'b0;
    mode32 = 1'b0;
    pixelCount = 8'd0;
    pixAck = 1'b0;
    pixData = '0;
    clearUnderrun = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = '0;
      lat[i] = 0;
    end
    test_reset();
    test_directed();
    test_mode32();
    test_random();
    test_underrun();
    test_loop();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/anton_neopixel_multi_stream.md
ANTON_NEOPIXEL_MULTI_STREAM -- requirements
Module: anton_neopixel_multi_stream

Interface
REQ-001 SHALL have parameter CHANNELS, default 4: number of parallel NeoPixel strings driven in lockstep.
REQ-002 SHALL have parameter PIXEL_MAX, default 255: highest supported pixel index; AW = CLOG2(PIXEL_MAX+1).
REQ-003 SHALL have parameter RESET_DELAY, default 400: sync-low length in clk6_4mhz cycles.
REQ-004 SHALL have port clk6_4mhz, input, 1: sole clock, 6.4 MHz; one clock, all logic rising-edge.
REQ-005 SHALL have port resetN, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port start, input, 1: frame start pulse, honoured only in IDLE.
REQ-007 SHALL have port stop, input, 1: pulse, cancels looping at the next frame end.
REQ-008 SHALL have port loop, input, 1: repeat frames; sampled at end of SYNC.
REQ-009 SHALL have port mode32, input, 1: 1 = 32 bits/pixel, 0 = 24; sampled on accepted start.
REQ-010 SHALL have port pixelCount, input, AW: last pixel index of a frame; sampled on accepted start.
REQ-011 SHALL have ports pixReq output 1, pixAddr output AW, pixAck input 1, pixData input CHANNELS*32 (channel c in bits [32c+31:32c]): pixel fetch handshake.
REQ-012 SHALL have port neoData, output, CHANNELS: serial outputs.
REQ-013 SHALL have ports busy output 1, frameDone output 1, underrun output 1, clearUnderrun input 1.

Function
REQ-014 SHALL implement states IDLE, FETCH, STREAM, SYNC; busy = (state != IDLE).
REQ-015 IDLE: start=1 -> FETCH next cycle, pixAddr=0, pixReq=1 (pixReq high one cycle after start).
REQ-016 Handshake: pixReq held high with pixAddr stable until a cycle with pixAck=1; pixData captured in that cycle; pixReq low the following cycle; pixAck while pixReq=0 ignored.
REQ-017 FETCH: on pixAck, load shift registers for all channels, go to STREAM; first neoData bit period starts the cycle after pixAck.
REQ-018 Bit period = 8 cycles, counter 0..7; neoData[c] = 1 when counter < 5 for bit 1, counter < 2 for bit 0; MSB first.
REQ-019 Bits sent per pixel: [31:0] in mode32, [23:0] otherwise; upper byte ignored in 24-bit mode.
REQ-020 STREAM: at first cycle of pixel i with i < pixelCount, issue request for pixAddr = i+1 into a one-deep next-pixel register per channel.
REQ-021 Last cycle of a pixel with i < pixelCount and next register valid: load shift registers, next pixel starts seamlessly (no gap).
REQ-022 Last cycle of pixel pixelCount -> SYNC.
REQ-023 Underrun: last cycle of a pixel with next register not valid -> set underrun (sticky), go to SYNC; outstanding request completes normally, its data discarded.
REQ-024 SYNC: neoData all 0 for exactly RESET_DELAY cycles; on last cycle frameDone=1 for one cycle.
REQ-025 End of SYNC: loop=1 and no stop pending -> FETCH addr 0; else IDLE; stop pending flag cleared on leaving SYNC and on entering FETCH from IDLE.
REQ-026 start while busy ignored; stop in IDLE ignored; pixelCount=0 sends one pixel per frame.
REQ-027 neoData SHALL be 0 in IDLE, FETCH and SYNC.
REQ-028 clearUnderrun=1 clears underrun; simultaneous new underrun wins (flag stays 1).

Reset
REQ-029 resetN=0 SHALL immediately force IDLE, neoData=0, pixReq=0, pixAddr=0, busy=0, frameDone=0, underrun=0, all counters and valid flags 0, stop pending 0.
REQ-030 Reset mid-frame or mid-handshake SHALL abandon the transfer; first cycle after deassert is IDLE with no request issued.

Verification
REQ-031 CHANNELS=2, mode32=0, pixelCount=1, ack 1 cycle after each req, ch0 data 0x800001 -> 24 bit periods starting cycle after ack: 5-high then 22x 2-high then 5-high; then 400 cycles low; frameDone one pulse; busy=0.
REQ-032 mode32=1, data 0xFF000000 -> first 8 bits 5-high, next 24 bits 2-high; 256 cycles per pixel, no gap between pixels.
REQ-033 pixAck withheld for pixel 1 beyond 192 cycles -> underrun=1 at pixel 0 end, SYNC entered, late ack accepted with pixReq dropping next cycle; clearUnderrun -> 0.
REQ-034 loop=1, pixelCount=0, 3 frames then stop -> exactly one frameDone per frame, IDLE after frame in which stop was seen, start during busy ignored.
REQ-035 resetN low mid-STREAM with pixReq high -> neoData=0, pixReq=0 same cycle; new start afterwards requests pixAddr=0.
